// File: rtl/playseq_motor_param_pkg.sv
// rtl/playseq_motor_param_pkg.sv - state codes, LFSR taps and helpers for the sequence-memory engine
package playseq_motor_param_pkg;

    // State codes, also shown on db_estado
    localparam logic [3:0] ST_INICIAL     = 4'h0;
    localparam logic [3:0] ST_PREPARA     = 4'h1;
    localparam logic [3:0] ST_ANEXA       = 4'h2;
    localparam logic [3:0] ST_MOSTRA_LED  = 4'h3;
    localparam logic [3:0] ST_MOSTRA_GAP  = 4'h4;
    localparam logic [3:0] ST_ESPERA      = 4'h5;
    localparam logic [3:0] ST_COMPARA     = 4'h6;
    localparam logic [3:0] ST_PROXIMA     = 4'h7;
    localparam logic [3:0] ST_FIM_GANHOU  = 4'hA;
    localparam logic [3:0] ST_FIM_PERDEU  = 4'hB;
    localparam logic [3:0] ST_FIM_TIMEOUT = 4'hC;

    // x^16 + x^14 + x^13 + x^11 + 1 -> bits 15, 13, 12, 10 feed back
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One Fibonacci step: shift left, XOR of the tapped bits enters at bit 0
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    // Largest of three durations, sizes the shared timer
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/playseq_motor_param_temporizador.sv
// rtl/playseq_motor_param_temporizador.sv - clear/enable counter flagging the last cycle of a limit
module playseq_temporizador #(
    parameter int M = 5000,
    localparam int W = $clog2(M) + 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limite_i,
    output logic         fim_o
);

    logic [W-1:0] count_q;

    // Counter restarts from zero on clear, otherwise advances while enabled
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Asserted during the final cycle of a limite_i-cycle interval
    assign fim_o = (count_q == limite_i - 1'b1);

endmodule

// File: rtl/playseq_motor_param.sv
// rtl/playseq_motor_param.sv - self-contained sequence-memory game engine with LFSR-built sequence
module playseq_motor_param
    import playseq_motor_param_pkg::*;
#(
    parameter int          N_BOTOES  = 4,
    parameter int          MAX_SEQ   = 16,
    parameter int          T_LED     = 500,
    parameter int          T_GAP     = 250,
    parameter int          T_TIMEOUT = 5000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                jogar,
    input  logic [1:0]          nivel,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] leds,
    output logic                pronto,
    output logic                ganhou,
    output logic                perdeu,
    output logic                timeout,
    output logic [3:0]          db_estado,
    output logic [5:0]          db_rodada
);

    localparam int SW    = $clog2(N_BOTOES);
    localparam int IW    = $clog2(MAX_SEQ);
    localparam int T_MAX = max3(T_LED, T_GAP, T_TIMEOUT);
    localparam int W_T   = $clog2(T_MAX) + 1;

    logic [3:0]          state_q, state_d;
    logic [5:0]          r_q, r_d;
    logic [5:0]          idx_q, idx_d;
    logic [5:0]          len_q, len_d;
    logic [15:0]         lfsr_q;
    logic [SW-1:0]       seq_q [MAX_SEQ];
    logic [N_BOTOES-1:0] sync1_q, sync2_q, prev_q, jogada_q;
    logic                move_q;

    logic [5:0]          r_m1;
    logic [IW-1:0]       wr_idx, rd_idx;
    logic [N_BOTOES-1:0] alvo;
    logic                tmr_clr, tmr_en, tmr_fim;
    logic [W_T-1:0]      tmr_lim;

    assign r_m1   = r_q - 6'd1;
    assign wr_idx = r_m1[IW-1:0];
    assign rd_idx = idx_q[IW-1:0];
    assign alvo   = N_BOTOES'(1) << seq_q[rd_idx];

    // Shared timer: restarted on every state change, limit chosen by the current state
    assign tmr_clr = (state_d != state_q);

    playseq_temporizador #(
        .M (T_MAX)
    ) u_temporizador (
        .clock    (clock),
        .reset    (reset),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .limite_i (tmr_lim),
        .fim_o    (tmr_fim)
    );

    // Two-flop synchroniser, rising-edge move detect, registered move only while waiting
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            jogada_q <= '0;
            move_q   <= 1'b0;
        end else begin
            sync1_q  <= botoes;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            jogada_q <= sync2_q;
            move_q   <= (state_q == ST_ESPERA) && (sync2_q != '0) && (prev_q == '0);
        end
    end

    // Free-running LFSR, stepping every clock so each game draws a fresh sequence
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    // Sequence memory: one element appended per round, wiped on reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_SEQ; i++) begin
                seq_q[i] <= '0;
            end
        end else if (state_q == ST_ANEXA) begin
            seq_q[wr_idx] <= lfsr_q[SW-1:0];
        end
    end

    // FSM state, round, index and target length registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INICIAL;
            r_q     <= '0;
            idx_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
        end
    end

    // Next-state logic; jogar only matters when idle or at game over
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        idx_d   = idx_q;
        len_d   = len_q;
        tmr_en  = 1'b0;
        tmr_lim = W_T'(T_LED);
        case (state_q)
            ST_INICIAL, ST_FIM_GANHOU, ST_FIM_PERDEU, ST_FIM_TIMEOUT: begin
                if (jogar) begin
                    state_d = ST_PREPARA;
                    len_d   = 6'((int'(nivel) + 1) * (MAX_SEQ / 4));
                    r_d     = 6'd1;
                    idx_d   = '0;
                end
            end
            ST_PREPARA: begin
                state_d = ST_ANEXA;
            end
            ST_ANEXA: begin
                state_d = ST_MOSTRA_LED;
                idx_d   = '0;
            end
            ST_MOSTRA_LED: begin
                tmr_en  = 1'b1;
                tmr_lim = W_T'(T_LED);
                if (tmr_fim) begin
                    state_d = ST_MOSTRA_GAP;
                end
            end
            ST_MOSTRA_GAP: begin
                tmr_en  = 1'b1;
                tmr_lim = W_T'(T_GAP);
                if (tmr_fim) begin
                    if (idx_q == r_m1) begin
                        state_d = ST_ESPERA;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_MOSTRA_LED;
                        idx_d   = idx_q + 6'd1;
                    end
                end
            end
            ST_ESPERA: begin
                tmr_en  = 1'b1;
                tmr_lim = W_T'(T_TIMEOUT);
                // A move arriving on the expiry cycle still counts
                if (move_q) begin
                    state_d = ST_COMPARA;
                end else if (tmr_fim) begin
                    state_d = ST_FIM_TIMEOUT;
                end
            end
            ST_COMPARA: begin
                if (jogada_q != alvo) begin
                    state_d = ST_FIM_PERDEU;
                end else if (idx_q < r_m1) begin
                    state_d = ST_ESPERA;
                    idx_d   = idx_q + 6'd1;
                end else begin
                    state_d = ST_PROXIMA;
                end
            end
            ST_PROXIMA: begin
                if (r_q == len_q) begin
                    state_d = ST_FIM_GANHOU;
                end else begin
                    state_d = ST_ANEXA;
                    r_d     = r_q + 6'd1;
                end
            end
            default: begin
                state_d = ST_INICIAL;
            end
        endcase
    end

    // LEDs show the preview element, echo the buttons while waiting, dark otherwise
    always_comb begin
        leds = '0;
        if (state_q == ST_MOSTRA_LED) begin
            leds = alvo;
        end else if (state_q == ST_ESPERA) begin
            leds = sync2_q;
        end
    end

    assign pronto    = (state_q == ST_FIM_GANHOU) || (state_q == ST_FIM_PERDEU) ||
                       (state_q == ST_FIM_TIMEOUT);
    assign ganhou    = (state_q == ST_FIM_GANHOU);
    assign perdeu    = (state_q == ST_FIM_PERDEU) || (state_q == ST_FIM_TIMEOUT);
    assign timeout   = (state_q == ST_FIM_TIMEOUT);
    assign db_estado = state_q;
    assign db_rodada = r_q;

endmodule

// File: tb/tb_playseq_motor_param.sv
// tb/tb_playseq_motor_param.sv - self-checking bench for the sequence-memory engine
module tb_playseq_motor_param;

    logic       clock = 1'b0;
    logic       reset;
    logic       jogar;
    logic [1:0] nivel;
    logic [3:0] botoes;
    logic [3:0] leds;
    logic       pronto, ganhou, perdeu, timeout;
    logic [3:0] db_estado;
    logic [5:0] db_rodada;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;
    logic [1:0]  seq_m[$];

    playseq_motor_param #(
        .N_BOTOES  (4),
        .MAX_SEQ   (16),
        .T_LED     (5),
        .T_GAP     (3),
        .T_TIMEOUT (20),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .jogar     (jogar),
        .nivel     (nivel),
        .botoes    (botoes),
        .leds      (leds),
        .pronto    (pronto),
        .ganhou    (ganhou),
        .perdeu    (perdeu),
        .timeout   (timeout),
        .db_estado (db_estado),
        .db_rodada (db_rodada)
    );

    always #5 clock = ~clock;

    // Polynomial x^16+x^14+x^13+x^11+1: XOR of the bits at each exponent position
    function automatic logic [15:0] poly_step(input logic [15:0] s);
        int   ex[4] = '{16, 14, 13, 11};
        logic fb;
        fb = 1'b0;
        for (int k = 0; k < 4; k++) fb = fb ^ s[ex[k]-1];
        return {s[14:0], fb};
    endfunction

    function automatic logic [3:0] oh(input logic [1:0] v);
        return 4'b0001 << v;
    endfunction

    // Reference LFSR runs from the seed on every clock
    always @(posedge clock or negedge reset) begin
        if (!reset) m_lfsr <= 16'hACE1;
        else        m_lfsr <= poly_step(m_lfsr);
    end

    // Each append cycle adds the model's low LFSR bits to the expected sequence
    always @(negedge clock) begin
        if (reset && db_estado == 4'h2) seq_m.push_back(m_lfsr[1:0]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [3:0] st, input int limit, input string tag);
        for (int n = 0; n < limit && db_estado !== st; n++) @(negedge clock);
        chk(tag, {28'd0, db_estado}, {28'd0, st});
    endtask

    task automatic start_game();
        @(negedge clock);
        seq_m.delete();
        jogar = 1'b1;
        @(negedge clock);
        jogar = 1'b0;
    endtask

    task automatic check_preview(input int r);
        wait_state(4'h3, 60, "preview_start");
        chk("preview_rodada", {26'd0, db_rodada}, r);
        for (int i = 0; i < r; i++) begin
            for (int c = 0; c < 5; c++) begin
                chk("led_on", {24'd0, db_estado, leds}, {24'd0, 4'h3, oh(seq_m[i])});
                @(negedge clock);
            end
            for (int c = 0; c < 3; c++) begin
                chk("led_gap", {24'd0, db_estado, leds}, {24'd0, 4'h4, 4'h0});
                @(negedge clock);
            end
        end
        chk("preview_to_espera", {28'd0, db_estado}, 32'h5);
    endtask

    task automatic press(input logic [3:0] v);
        @(negedge clock);
        botoes = v;
        repeat (3) @(negedge clock);
        botoes = 4'b0000;
    endtask

    task automatic play_moves(input int r);
        for (int i = 0; i < r; i++) begin
            press(oh(seq_m[i]));
            wait_state(4'h6, 4, "compara");
        end
    endtask

    initial begin
        reset  = 1'b0;
        jogar  = 1'b0;
        nivel  = 2'd0;
        botoes = 4'b0000;
        repeat (3) @(negedge clock);
        chk("reset_outputs", {25'd0, leds, pronto, ganhou, perdeu, timeout}, 32'h0);
        chk("reset_estado", {28'd0, db_estado}, 32'h0);
        chk("reset_rodada", {26'd0, db_rodada}, 32'h0);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        chk("idle_estado", {28'd0, db_estado}, 32'h0);

        // Full win at nivel 0: four rounds
        start_game();
        for (int r = 1; r <= 4; r++) begin
            check_preview(r);
            play_moves(r);
        end
        wait_state(4'hA, 6, "ganhou_estado");
        chk("ganhou_flags", {28'd0, pronto, ganhou, perdeu, timeout}, 32'b1100);
        chk("ganhou_leds", {28'd0, leds}, 32'h0);
        chk("ganhou_rodada", {26'd0, db_rodada}, 32'd4);
        repeat (10) @(negedge clock);
        chk("ganhou_held", {24'd0, db_estado, pronto, ganhou, perdeu, timeout}, {24'd0, 4'hA, 4'b1100});

        // Wrong second move in round 2, with an ignored jogar during play
        start_game();
        check_preview(1);
        play_moves(1);
        check_preview(2);
        jogar = 1'b1;
        @(negedge clock);
        jogar = 1'b0;
        chk("jogar_ignorado", {28'd0, db_estado}, 32'h5);
        press(oh(seq_m[0]));
        wait_state(4'h6, 4, "compara_r2");
        press(oh(seq_m[1] + 2'd1 + 2'($urandom_range(0, 2))));
        wait_state(4'hB, 4, "perdeu_estado");
        chk("perdeu_flags", {28'd0, pronto, ganhou, perdeu, timeout}, 32'b1010);

        // No move: timeout after exactly 20 waiting cycles
        start_game();
        check_preview(1);
        repeat (19) @(negedge clock);
        chk("espera_19", {28'd0, db_estado}, 32'h5);
        @(negedge clock);
        chk("timeout_estado", {28'd0, db_estado}, 32'hC);
        chk("timeout_flags", {28'd0, pronto, ganhou, perdeu, timeout}, 32'b1011);

        // Multi-hot press loses
        start_game();
        check_preview(1);
        press(4'b0011);
        wait_state(4'hB, 4, "multihot_estado");
        chk("multihot_flags", {28'd0, pronto, ganhou, perdeu, timeout}, 32'b1010);

        // Correct move landing on the expiry cycle keeps the game going
        start_game();
        check_preview(1);
        repeat (15) @(negedge clock);
        press(oh(seq_m[0]));
        wait_state(4'h6, 4, "compara_expira");
        check_preview(2);
        wait_state(4'hC, 30, "timeout_r2");

        // Reset in the middle of round 3 preview
        start_game();
        for (int r = 1; r <= 2; r++) begin
            check_preview(r);
            play_moves(r);
        end
        wait_state(4'h3, 60, "preview_r3");
        chk("preview_r3_rodada", {26'd0, db_rodada}, 32'd3);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("midreset_outputs", {25'd0, leds, pronto, ganhou, perdeu, timeout}, 32'h0);
        chk("midreset_estado", {28'd0, db_estado}, 32'h0);
        chk("midreset_rodada", {26'd0, db_rodada}, 32'h0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("after_reset_idle", {28'd0, db_estado}, 32'h0);
        start_game();
        check_preview(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
